// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one physical-memory line port between the instruction cache (I)
//   and the data cache (D). One line transaction is in flight at a time. The
//   winner's request is latched and the memory port is driven from registers.
//   The response and the read line go back to the winning cache only.
//   Arbitration is round-robin. A data-cache writeback locks the next
//   arbitration to a data-cache refill, so the writeback and its refill stay
//   back-to-back.
//
// Handshake: each cache holds its request (i_read / d_read / d_write) as a
//   level until its one-cycle *_resp pulse. It drops or changes the request
//   from the cycle after that pulse. The memory side works the same way:
//   pmem_read / pmem_write stay high until a one-cycle pmem_resp. pmem_rdata
//   is valid only while pmem_resp is high.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_address, i_read        icache line read request
//   i_rdata, i_resp          line and completion pulse returned to icache
//   d_address, d_read,
//   d_write, d_wdata         dcache refill / writeback request
//   d_rdata, d_resp          line and completion pulse returned to dcache
//   pmem_address, pmem_read,
//   pmem_write, pmem_wdata   registered request to main memory
//   pmem_rdata, pmem_resp    main-memory response
//   dbg_state                current FSM state (0 IDLE, 1 SERVE, 2 DONE)
module cache_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_address,
    input  logic              i_read,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Clears the line-offset bits so memory always sees an aligned address.
    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

    state_t state, state_n;

    // grant / last_grant: 0 = icache, 1 = dcache
    logic              grant, grant_n;
    logic              is_write, is_write_n;
    logic              last_grant, last_grant_n;
    logic              lock, lock_n;
    logic [31:0]       addr_n;
    logic [s_line-1:0] wdata_n;
    logic              read_n, write_n;
    logic              i_resp_n, d_resp_n;
    logic [s_line-1:0] i_rdata_n, d_rdata_n;
    logic              d_req;
    logic              pick_d;

    assign d_req     = d_read | d_write;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            is_write     <= 1'b0;
            last_grant   <= 1'b1;  // first tie goes to the icache
            lock         <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            is_write     <= is_write_n;
            last_grant   <= last_grant_n;
            lock         <= lock_n;
            pmem_address <= addr_n;
            pmem_wdata   <= wdata_n;
            pmem_read    <= read_n;
            pmem_write   <= write_n;
            i_resp       <= i_resp_n;
            d_resp       <= d_resp_n;
            i_rdata      <= i_rdata_n;
            d_rdata      <= d_rdata_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        is_write_n   = is_write;
        last_grant_n = last_grant;
        lock_n       = lock;
        addr_n       = pmem_address;
        wdata_n      = pmem_wdata;
        read_n       = pmem_read;
        write_n      = pmem_write;
        i_resp_n     = 1'b0;
        d_resp_n     = 1'b0;
        i_rdata_n    = i_rdata;
        d_rdata_n    = d_rdata;
        pick_d       = 1'b0;

        case (state)
            IDLE: begin
                if (i_read || d_req) begin
                    if (i_read && d_req) begin
                        // Tie: take the side not served last, unless the
                        // last job was a dcache writeback and the dcache now
                        // wants its refill.
                        pick_d = (lock && d_read) ? 1'b1 : ~last_grant;
                    end else begin
                        pick_d = d_req;
                    end
                    grant_n    = pick_d;
                    // If read and write are both high, treat the request as a write.
                    is_write_n = pick_d & d_write;
                    addr_n     = (pick_d ? d_address : i_address) & addr_mask;
                    wdata_n    = d_wdata;
                    read_n     = ~is_write_n;
                    write_n    = is_write_n;
                    lock_n     = 1'b0;
                    state_n    = SERVE;
                end
            end
            SERVE: begin
                if (pmem_resp) begin
                    read_n       = 1'b0;
                    write_n      = 1'b0;
                    last_grant_n = grant;
                    lock_n       = grant & is_write;
                    if (grant) begin
                        d_rdata_n = pmem_rdata;
                        d_resp_n  = 1'b1;
                    end else begin
                        i_rdata_n = pmem_rdata;
                        i_resp_n  = 1'b1;
                    end
                    state_n = DONE;
                end
            end
            DONE: begin
                // The response pulse is high during this cycle. This extra
                // cycle keeps a request that just completed from being
                // granted again before the cache drops it.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   i_address;
    logic          i_read;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [31:0]   d_address;
    logic          d_read;
    logic          d_write;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [31:0]   pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [1:0]    dbg_state;

    logic          mem_resp;
    logic          spur_resp;
    assign pmem_resp = mem_resp | spur_resp;

    int checks = 0;
    int errors = 0;
    int i_cnt  = 0;
    int d_cnt  = 0;
    int read_hi = 0;

    typedef struct packed {
        logic [31:0]   addr;
        logic          wr;
        logic [LW-1:0] wdata;
        logic [7:0]    lat;
    } pmem_exp_t;

    typedef struct packed {
        logic          side;  // 0 icache, 1 dcache
        logic [LW-1:0] data;
    } resp_exp_t;

    pmem_exp_t pmem_q[$];
    resp_exp_t resp_q[$];

    cache_arbiter #(.s_offset(5), .s_line(LW)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [LW-1:0] mem_line(input logic [31:0] a);
        return {4{a, a ^ 32'hDEAD_BEEF}};
    endfunction

    function automatic logic [LW-1:0] wr_line(input logic [31:0] a);
        return {8{a ^ 32'h0F0F_F0F0}};
    endfunction

    task automatic exp_pm(input logic [31:0] a, input logic wr, input logic [LW-1:0] wd,
                          input logic [7:0] lat);
        pmem_exp_t e;
        e.addr = a; e.wr = wr; e.wdata = wd; e.lat = lat;
        pmem_q.push_back(e);
    endtask

    task automatic exp_rs(input logic side, input logic [31:0] a);
        resp_exp_t r;
        r.side = side; r.data = mem_line(a);
        resp_q.push_back(r);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (i_rdata !== '0 || i_resp !== 1'b0 || d_rdata !== '0 || d_resp !== 1'b0 ||
            pmem_address !== '0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 ||
            pmem_wdata !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL %s outputs not zero: pmem_address=%h rd=%b wr=%b i_resp=%b d_resp=%b state=%0d required all zero",
                     name, pmem_address, pmem_read, pmem_write, i_resp, d_resp, dbg_state);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_i(input logic [31:0] a);
        int n;
        n = 0;
        i_address = a;
        i_read    = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!i_resp && n < 200);
        i_read = 1'b0;
        checks++;
        if (!i_resp) begin
            errors++;
            $display("FAIL i_timeout addr=%h got=no_resp required=resp within 200 cycles", a);
        end
    endtask

    task automatic do_d(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [LW-1:0] wd);
        int n;
        n = 0;
        d_address = a;
        d_read    = rd;
        d_write   = wr;
        d_wdata   = wd;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!d_resp && n < 200);
        d_read  = 1'b0;
        d_write = 1'b0;
        checks++;
        if (!d_resp) begin
            errors++;
            $display("FAIL d_timeout addr=%h got=no_resp required=resp within 200 cycles", a);
        end
    endtask

    task automatic apply_reset();
        rst     = 1'b0;
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- memory model ----------------
    initial begin
        pmem_exp_t e;
        mem_resp   = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst && (pmem_read || pmem_write)) begin
                checks++;
                if (pmem_q.size() == 0) begin
                    errors++;
                    $display("FAIL pmem_unexpected got addr=%h rd=%b wr=%b required=no request",
                             pmem_address, pmem_read, pmem_write);
                    mem_resp   = 1'b1;
                    pmem_rdata = '0;
                    @(posedge clk); #1;
                    mem_resp = 1'b0;
                end else begin
                    e = pmem_q.pop_front();
                    if (pmem_address !== e.addr || pmem_write !== e.wr || pmem_read !== ~e.wr ||
                        (e.wr && pmem_wdata !== e.wdata)) begin
                        errors++;
                        $display("FAIL pmem_req got addr=%h rd=%b wr=%b wdata=%h required addr=%h wr=%b wdata=%h",
                                 pmem_address, pmem_read, pmem_write, pmem_wdata[31:0],
                                 e.addr, e.wr, e.wdata[31:0]);
                    end
                    repeat (int'(e.lat) - 1) begin
                        @(posedge clk); #1;
                    end
                    mem_resp   = 1'b1;
                    pmem_rdata = mem_line(e.addr);
                    @(posedge clk); #1;
                    mem_resp = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        resp_exp_t r;
        logic [LW-1:0] got;
        forever begin
            @(negedge clk);
            if (pmem_read) read_hi++;
            if (pmem_read && pmem_write) begin
                checks++;
                errors++;
                $display("FAIL dual_strobe got rd=1 wr=1 required at most one");
            end
            if (i_resp && d_resp) begin
                checks++;
                errors++;
                $display("FAIL resp_overlap got i_resp=1 d_resp=1 required at most one");
            end
            if (i_resp) i_cnt++;
            if (d_resp) d_cnt++;
            if (i_resp || d_resp) begin
                checks++;
                if (resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got i_resp=%b d_resp=%b required none",
                             i_resp, d_resp);
                end else begin
                    r   = resp_q.pop_front();
                    got = d_resp ? d_rdata : i_rdata;
                    if (d_resp !== r.side || got !== r.data) begin
                        errors++;
                        $display("FAIL resp got side=%b data=%h required side=%b data=%h",
                                 d_resp, got[63:0], r.side, r.data[63:0]);
                    end
                end
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        int i0;
        int d0;
        rst       = 1'b0;
        spur_resp = 1'b0;
        i_address = '0;
        i_read    = 1'b0;
        d_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_wdata   = '0;

        // reset values
        #2;
        check_zero("reset_outputs");
        apply_reset();
        check_zero("post_reset_idle");

        // 1: solo icache read, 4-cycle memory
        read_hi = 0; i0 = i_cnt; d0 = d_cnt;
        exp_pm(32'h0000_1220, 1'b0, '0, 8'd4);
        exp_rs(1'b0, 32'h0000_1220);
        do_i(32'h0000_1234);
        repeat (2) @(posedge clk); #1;
        check("solo_read_hi_cycles", 64'(read_hi), 64'd4);
        check("solo_i_resp_count", 64'(i_cnt - i0), 64'd1);
        check("solo_d_resp_count", 64'(d_cnt - d0), 64'd0);

        // 2: simultaneous from reset -> icache then dcache
        apply_reset();
        i0 = i_cnt; d0 = d_cnt;
        exp_pm(32'h0000_2000, 1'b0, '0, 8'd2);
        exp_pm(32'h0000_3000, 1'b0, '0, 8'd1);
        exp_rs(1'b0, 32'h0000_2000);
        exp_rs(1'b1, 32'h0000_3000);
        fork
            do_i(32'h0000_2000);
            do_d(32'h0000_3000, 1'b1, 1'b0, '0);
        join
        repeat (2) @(posedge clk); #1;
        check("tie_i_resp_count", 64'(i_cnt - i0), 64'd1);
        check("tie_d_resp_count", 64'(d_cnt - d0), 64'd1);

        // 3: continuous requests, strict alternation I,D,I,D...
        for (int k = 0; k < 4; k++) begin
            exp_pm(32'h0000_4000 + 32'(k * 64), 1'b0, '0, 8'(k % 3 + 1));
            exp_rs(1'b0, 32'h0000_4000 + 32'(k * 64));
            exp_pm(32'h0000_5000 + 32'(k * 64), 1'b0, '0, 8'((k + 1) % 3 + 1));
            exp_rs(1'b1, 32'h0000_5000 + 32'(k * 64));
        end
        fork
            for (int k = 0; k < 4; k++) do_i(32'h0000_4000 + 32'(k * 64));
            for (int k = 0; k < 4; k++) do_d(32'h0000_5000 + 32'(k * 64), 1'b1, 1'b0, '0);
        join
        repeat (2) @(posedge clk); #1;

        // 4: writeback then locked refill ahead of a waiting icache
        exp_pm(32'h8000_0040, 1'b1, wr_line(32'h8000_0040), 8'd2);
        exp_rs(1'b1, 32'h8000_0040);
        exp_pm(32'h9000_0000, 1'b0, '0, 8'd3);
        exp_rs(1'b1, 32'h9000_0000);
        exp_pm(32'h0000_6000, 1'b0, '0, 8'd1);
        exp_rs(1'b0, 32'h0000_6000);
        exp_pm(32'h0000_6040, 1'b0, '0, 8'd1);
        exp_rs(1'b0, 32'h0000_6040);
        fork
            begin
                do_d(32'h8000_0040, 1'b0, 1'b1, wr_line(32'h8000_0040));
                do_d(32'h9000_0000, 1'b1, 1'b0, '0);
            end
            begin
                @(posedge clk); #1;
                do_i(32'h0000_6000);
                do_i(32'h0000_6040);
            end
        join
        repeat (2) @(posedge clk); #1;

        // 5: reset during SERVE aborts silently
        exp_pm(32'h0000_7000, 1'b0, '0, 8'd6);
        i_address = 32'h0000_7000;
        i_read    = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("abort_in_serve", 64'(dbg_state), 64'd1);
        rst    = 1'b0;
        i_read = 1'b0;
        #1;
        check_zero("abort_async_reset");
        repeat (2) @(posedge clk); #1;
        check_zero("abort_held_reset");
        rst = 1'b1;
        i0 = i_cnt; d0 = d_cnt;
        repeat (10) @(posedge clk); #1;
        check("abort_no_i_resp", 64'(i_cnt - i0), 64'd0);
        check("abort_no_d_resp", 64'(d_cnt - d0), 64'd0);
        exp_pm(32'hA000_0000, 1'b0, '0, 8'd1);
        exp_rs(1'b1, 32'hA000_0000);
        do_d(32'hA000_0010, 1'b1, 1'b0, '0);
        repeat (2) @(posedge clk); #1;
        check("fresh_d_resp_count", 64'(d_cnt - d0), 64'd1);

        // 6: spurious pmem_resp in IDLE, then dual strobe treated as write
        i0 = i_cnt; d0 = d_cnt;
        spur_resp = 1'b1;
        @(posedge clk); #1;
        spur_resp = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("spur_state_idle", 64'(dbg_state), 64'd0);
        check("spur_no_strobe", 64'({pmem_read, pmem_write}), 64'd0);
        check("spur_no_resp", 64'((i_cnt - i0) + (d_cnt - d0)), 64'd0);
        exp_pm(32'hB000_0000, 1'b1, wr_line(32'hB000_0000), 8'd2);
        exp_rs(1'b1, 32'hB000_0000);
        do_d(32'hB000_0000, 1'b1, 1'b1, wr_line(32'hB000_0000));
        repeat (3) @(posedge clk); #1;

        check("pmem_queue_drained", 64'(pmem_q.size()), 64'd0);
        check("resp_queue_drained", 64'(resp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory line port between the instruction cache and the data cache. Sits between both caches' memory-side interfaces and the cacheline adaptor / main-memory model. It accepts at most one line transaction at a time, latches the winner's request, drives the memory port from registers, and returns the response and read data to the winning cache only. Arbitration is round-robin with a data-cache eviction lock, so a dirty writeback and its refill stay back-to-back.

## Interface
- s_offset, default 5: line offset bits; address bits [s_offset-1:0] are forced to 0 on pmem_address.
- s_line, default 256: line width in bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_address  in  32  icache line request address.
- i_read  in  1  icache line read request; level, held until i_resp.
- i_rdata  out  s_line  line returned to icache; valid when i_resp=1.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_address  in  32  dcache line request address.
- d_read  in  1  dcache line read (refill) request.
- d_write  in  1  dcache line write (writeback) request.
- d_wdata  in  s_line  line to write.
- d_rdata  out  s_line  line returned to dcache; valid when d_resp=1.
- d_resp  out  1  one-cycle completion pulse to dcache.
- pmem_address  out  32  line address to memory.
- pmem_read  out  1  memory read strobe; level until pmem_resp.
- pmem_write  out  1  memory write strobe; level until pmem_resp.
- pmem_wdata  out  s_line  write line.
- pmem_rdata  in  s_line  read line; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.

## Operation
- States: IDLE, SERVE, DONE. Registers: grant (0=I, 1=D), is_write, last_grant, lock, latched address/wdata, rdata buffer.
- IDLE: requests pending = i_read, d_req = d_read|d_write. None -> stay. One -> grant it. Both -> grant the side opposite last_grant, unless lock=1 and d_read=1, then grant D. On grant: latch address (low s_offset bits zeroed), d_wdata, is_write = d_write (D only); go SERVE.
- d_read and d_write both high is illegal; arbiter treats it as a write.
- SERVE: pmem_read = ~is_write, pmem_write = is_write, address/wdata from latches; inputs from caches ignored. On pmem_resp: capture pmem_rdata, last_grant <= grant, lock <= (grant==D && is_write); go DONE.
- DONE: pmem_read/pmem_write low; i_resp or d_resp (winner only) high for exactly this cycle with buffered rdata on i_rdata/d_rdata; go IDLE.
- lock clears on any grant made in IDLE (it applies to the single next arbitration only).
- pmem_resp in IDLE or DONE is ignored.
- Requesters drop their request in the cycle after resp; the DONE->IDLE bubble guarantees a completed request is never re-granted.

## Timing
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including pmem_address, pmem_wdata, i_rdata, d_rdata; last_grant=D (first tie goes to I); lock=0. Reset asserted mid-SERVE aborts silently; no resp is ever issued for the aborted transaction.
- Request seen in IDLE at cycle 0 -> pmem strobe high from cycle 1 -> pmem_resp at cycle k -> strobe low and *_resp high at cycle k+1 -> IDLE at k+2. Minimum 3 cycles request-to-resp with a 1-cycle memory.
- All outputs registered; no combinational path from any input to any output.
- Back-to-back: a new grant is possible in the IDLE cycle immediately after DONE.

## Test plan
- Solo icache read 0x0000_1234, memory returns line A after 4 cycles -> pmem_address=0x0000_1220, pmem_read high 4 cycles, i_resp one pulse with i_rdata=A, d_resp stays 0.
- Simultaneous i_read and d_read from reset -> icache served first, then dcache; each resp exactly once, correct data per side, no overlap on pmem.
- Continuous requests from both for 8 transactions -> grants strictly alternate I,D,I,D...; neither starves.
- Dcache writeback 0x8000_0040 then refill 0x9000_0000 while icache reads continuously -> write (pmem_wdata=d_wdata), then dcache read granted immediately before icache; then icache.
- Assert rst during SERVE, release, issue fresh dcache read -> all outputs 0 during reset, no spurious resp, new transaction completes normally.
- Spurious pmem_resp in IDLE; d_read and d_write both high -> no resp or state change in IDLE; dual strobe performs pmem_write only.
